eth_rx_filter: RTL and testbench

ETH_RX_FILTER -- requirements
Module: eth_rx_filter

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_rx_filter_if.sv | 18 +
 rtl/eth_hdr_buf4.sv | 76 +++++++
 rtl/eth_rx_filter.sv | 197 +++++++++++++++++++
 tb/tb_eth_rx_filter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared constants for the Ethernet RX filter: f36 word layout,
//            broadcast address and filter FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

   localparam int F36_W   = 36;
   localparam int SOF     = 32;
   localparam int EOF     = 33;
   localparam int OCC_LSB = 34;

   localparam logic [47:0] BCAST_ADDR = 48'hffff_ffff_ffff;

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_HDR   = 3'd1;
   localparam logic [2:0] c_ST_FLUSH = 3'd2;
   localparam logic [2:0] c_ST_PASS  = 3'd3;
   localparam logic [2:0] c_ST_DROP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/eth_rx_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_filter_if
// Purpose  : f36 streaming port (data + src_rdy/dst_rdy handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface eth_rx_filter_if;
   import eth_pkg::*;

   logic [F36_W-1:0] data;
   logic             src_rdy;
   logic             dst_rdy;

   modport master (output data, output src_rdy, input dst_rdy);
   modport slave  (input data, input src_rdy, output dst_rdy);

endinterface
`default_nettype wire

// File: rtl/eth_hdr_buf4.sv
`default_nettype none
// ============================================================================
// Module   : eth_hdr_buf4
// Purpose  : Four-slot header buffer with write/read pointers; holds the
//            header words while the accept/drop decision is pending.
// Revision : 1.0 - initial release
// ============================================================================
module eth_hdr_buf4
   import eth_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             flush,
   input  wire logic             wr_en,
   input  wire logic             wr_restart,
   input  wire logic [F36_W-1:0] wr_data,
   input  wire logic             rd_en,
   output logic      [F36_W-1:0] rd_data,
   output logic      [31:0]      dst_hi,
   output logic      [15:0]      dst_lo,
   output logic      [2:0]       wr_cnt,
   output logic                  rd_last
);

   logic [2:0] r_wr_ptr;
   logic [1:0] r_rd_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         logic [F36_W-1:0] r_q;
         // A restart (sof inside the header) always lands in slot 0.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               r_q <= '0;
            else if (wr_en && (wr_restart ? (gi == 0) : (r_wr_ptr == 3'(gi))))
               r_q <= wr_data;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (wr_en)
            r_wr_ptr <= wr_restart ? 3'd1 : r_wr_ptr + 3'd1;
         if (rd_en) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
            if (r_rd_ptr == 2'd3)
               r_wr_ptr <= '0;
         end
      end
   end

   always_comb begin
      rd_data = g_slot[0].r_q;
      case (r_rd_ptr)
         2'd1:    rd_data = g_slot[1].r_q;
         2'd2:    rd_data = g_slot[2].r_q;
         2'd3:    rd_data = g_slot[3].r_q;
         default: rd_data = g_slot[0].r_q;
      endcase
   end

   assign dst_hi  = g_slot[0].r_q[31:0];
   assign dst_lo  = g_slot[1].r_q[31:16];
   assign wr_cnt  = r_wr_ptr;
   assign rd_last = (r_rd_ptr == 2'd3);

endmodule
`default_nettype wire

// File: rtl/eth_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_filter
// Purpose  : Buffers the first four f36 header words, accepts frames by
//            destination MAC and EtherType, then passes or drops the frame.
//            Define ETH_RX_FILTER_STATS_EN to build the frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_filter
   import eth_pkg::*;
#(
   parameter int PASS_BCAST = 1,
   parameter int HDR_WORDS  = 4
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   input  wire logic          clear,
   input  wire logic [47:0]   ucast_addr,
   input  wire logic [15:0]   ethertype,
   eth_rx_filter_if.slave     i_f36,
   eth_rx_filter_if.master    o_f36
`ifdef ETH_RX_FILTER_STATS_EN
   ,
   output logic      [15:0]   frames_ok,
   output logic      [15:0]   frames_drop,
   output logic      [15:0]   frames_runt
`endif
);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nx;
   logic             r_out_en;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_in_sof;
   logic             w_in_eof;
   logic [2:0]       w_idx;
   logic             w_hdr_last;
   logic             w_accept;
   logic             w_runt;
   logic [47:0]      w_dst;
   logic             w_buf_wr;
   logic             w_buf_restart;
   logic             w_buf_rd;
   logic             w_buf_flush;
   logic [F36_W-1:0] w_rd_data;
   logic [31:0]      w_dst_hi;
   logic [15:0]      w_dst_lo;
   logic [2:0]       w_wr_cnt;
   logic             w_rd_last;

   eth_hdr_buf4 u_hdr_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (w_buf_flush),
      .wr_en      (w_buf_wr),
      .wr_restart (w_buf_restart),
      .wr_data    (i_f36.data),
      .rd_en      (w_buf_rd),
      .rd_data    (w_rd_data),
      .dst_hi     (w_dst_hi),
      .dst_lo     (w_dst_lo),
      .wr_cnt     (w_wr_cnt),
      .rd_last    (w_rd_last)
   );

   assign w_in_sof   = i_f36.data[SOF];
   assign w_in_eof   = i_f36.data[EOF];
   assign w_in_xfer  = i_f36.src_rdy && i_f36.dst_rdy;
   assign w_out_xfer = o_f36.src_rdy && o_f36.dst_rdy;

   // The last header word is filtered as it arrives, before it is stored.
   assign w_idx      = w_in_sof ? 3'd0 : w_wr_cnt;
   assign w_hdr_last = (r_state == c_ST_HDR) && (w_idx == 3'(HDR_WORDS - 1));
   assign w_dst      = {w_dst_hi, w_dst_lo};
   assign w_accept   = (i_f36.data[31:16] == ethertype) &&
                       ((w_dst == ucast_addr) || ((PASS_BCAST != 0) && (w_dst == BCAST_ADDR)));
   assign w_runt     = w_in_xfer && w_in_eof &&
                       (((r_state == c_ST_IDLE) && w_in_sof) ||
                        ((r_state == c_ST_HDR) && !w_hdr_last));

   // Handshakes are masked during clear so no word is half-consumed.
   always_comb begin
      i_f36.dst_rdy = 1'b0;
      o_f36.src_rdy = 1'b0;
      o_f36.data    = '0;
      case (r_state)
         c_ST_IDLE, c_ST_HDR, c_ST_DROP: i_f36.dst_rdy = r_out_en && !clear;
         c_ST_FLUSH: begin
            o_f36.src_rdy = !clear;
            o_f36.data    = w_rd_data;
         end
         c_ST_PASS: begin
            o_f36.src_rdy = i_f36.src_rdy && !clear;
            o_f36.data    = i_f36.data;
            i_f36.dst_rdy = o_f36.dst_rdy && !clear;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nx    = r_state;
      w_buf_wr      = 1'b0;
      w_buf_restart = 1'b0;
      w_buf_rd      = 1'b0;
      w_buf_flush   = 1'b0;
      if (clear) begin
         w_state_nx  = c_ST_IDLE;
         w_buf_flush = 1'b1;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_in_xfer && w_in_sof) begin
                  if (w_in_eof) begin
                     w_buf_flush = 1'b1;
                  end else begin
                     w_buf_wr      = 1'b1;
                     w_buf_restart = 1'b1;
                     w_state_nx    = c_ST_HDR;
                  end
               end
            end
            c_ST_HDR: begin
               if (w_in_xfer) begin
                  if (w_hdr_last) begin
                     if (w_accept) begin
                        w_buf_wr   = 1'b1;
                        w_state_nx = c_ST_FLUSH;
                     end else begin
                        w_buf_flush = 1'b1;
                        w_state_nx  = w_in_eof ? c_ST_IDLE : c_ST_DROP;
                     end
                  end else if (w_in_eof) begin
                     w_buf_flush = 1'b1;
                     w_state_nx  = c_ST_IDLE;
                  end else begin
                     w_buf_wr      = 1'b1;
                     w_buf_restart = w_in_sof;
                  end
               end
            end
            c_ST_FLUSH: begin
               if (w_out_xfer) begin
                  w_buf_rd = 1'b1;
                  if (w_rd_last)
                     w_state_nx = w_rd_data[EOF] ? c_ST_IDLE : c_ST_PASS;
               end
            end
            c_ST_PASS, c_ST_DROP: begin
               if (w_in_xfer && w_in_eof)
                  w_state_nx = c_ST_IDLE;
            end
            default: w_state_nx = c_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= c_ST_IDLE;
         r_out_en <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_out_en <= 1'b1;
      end
   end

`ifdef ETH_RX_FILTER_STATS_EN
   logic [15:0] r_frames_ok;
   logic [15:0] r_frames_drop;
   logic [15:0] r_frames_runt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frames_ok   <= '0;
         r_frames_drop <= '0;
         r_frames_runt <= '0;
      end else begin
         if (w_in_xfer && w_hdr_last) begin
            if (w_accept)
               r_frames_ok <= r_frames_ok + 16'd1;
            else
               r_frames_drop <= r_frames_drop + 16'd1;
         end
         if (w_runt)
            r_frames_runt <= r_frames_runt + 16'd1;
      end
   end

   assign frames_ok   = r_frames_ok;
   assign frames_drop = r_frames_drop;
   assign frames_runt = r_frames_runt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_filter
// Purpose  : Directed self-checking bench for eth_rx_filter (both PASS_BCAST
//            settings); counter checks are built with ETH_RX_FILTER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_filter;
   import eth_pkg::*;

   localparam logic [47:0] UCAST = 48'h0050_c285_3fff;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear   = 1'b0;
   logic [47:0] ucast_addr = UCAST;
   logic [15:0] ethertype  = 16'h0800;

   eth_rx_filter_if i_f36 ();
   eth_rx_filter_if o_f36 ();
   eth_rx_filter_if i2 ();
   eth_rx_filter_if o2 ();

`ifdef ETH_RX_FILTER_STATS_EN
   logic [15:0] ok, drop, runt, ok2, drop2, runt2;
`endif

   eth_rx_filter #(.PASS_BCAST(1), .HDR_WORDS(4)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .ucast_addr(ucast_addr), .ethertype(ethertype),
      .i_f36(i_f36), .o_f36(o_f36)
`ifdef ETH_RX_FILTER_STATS_EN
      , .frames_ok(ok), .frames_drop(drop), .frames_runt(runt)
`endif
   );

   eth_rx_filter #(.PASS_BCAST(0), .HDR_WORDS(4)) dut_nb (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .ucast_addr(ucast_addr), .ethertype(ethertype),
      .i_f36(i2), .o_f36(o2)
`ifdef ETH_RX_FILTER_STATS_EN
      , .frames_ok(ok2), .frames_drop(drop2), .frames_runt(runt2)
`endif
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [35:0] tx[$];
   logic [35:0] exp_q[$];
   logic [35:0] rx[$];
   bit          all_rdy;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Frame layout: dst | src | type | payload; eof word carries occ=2.
   task automatic mk_frame(input logic [47:0] dst, input logic [15:0] typ, input int n);
      logic [31:0] d;
      tx.delete();
      for (int i = 0; i < n; i++) begin
         case (i)
            0:       d = dst[47:16];
            1:       d = {dst[15:0], 16'h1234};
            2:       d = 32'h5678_9abc;
            3:       d = {typ, 16'h4500};
            default: d = 32'ha000_0000 + 32'(i);
         endcase
         tx.push_back({(i == n - 1) ? 2'd2 : 2'd0, i == n - 1, i == 0, d});
      end
      exp_q = tx;
   endtask

   task automatic check_rx(input string tag, input int n_exp);
      logic [35:0] o_w = '0;
      logic [35:0] e_w = '0;
      bit found = 0;
      check({tag, " count"}, 36'(rx.size()), 36'(n_exp));
      for (int i = 0; i < n_exp && i < rx.size(); i++) begin
         if (!found && rx[i] !== exp_q[i]) begin
            found = 1;
            o_w   = rx[i];
            e_w   = exp_q[i];
         end
      end
      check({tag, " data"}, o_w, e_w);
   endtask

   // Drives tx, captures output transfers. akind: 1=reset pulse, 2=clear pulse at input index aat.
   task automatic run(input bit sel, input int dmode, input int akind, input int aat);
      int idx = 0;
      int idle = 0;
      int cyc = 0;
      bit aborted = 0;
      bit in_dst, o_src;
      logic [35:0] o_dat;
      rx.delete();
      all_rdy = 1;
      while (idle < 8 && cyc < 3000) begin
         @(negedge clk);
         if (akind != 0 && !aborted && idx == aat) begin
            aborted = 1;
            i_f36.src_rdy = 0;
            i2.src_rdy    = 0;
            if (akind == 1) begin
               reset_n = 0;
               #1;
               check("rst dst_rdy", 36'(i_f36.dst_rdy), 36'd0);
               check("rst src_rdy", 36'(o_f36.src_rdy), 36'd0);
               check("rst data", o_f36.data, 36'd0);
            end else begin
               clear = 1;
            end
            @(negedge clk);
            reset_n = 1;
            clear   = 0;
         end
         i_f36.src_rdy = (idx < tx.size());
         i_f36.data    = (idx < tx.size()) ? tx[idx] : 36'd0;
         i2.src_rdy    = i_f36.src_rdy;
         i2.data       = i_f36.data;
         o_f36.dst_rdy = (dmode == 0) ? 1'b1 : (cyc % 2 == 0);
         o2.dst_rdy    = o_f36.dst_rdy;
         #1;
         in_dst = sel ? i2.dst_rdy : i_f36.dst_rdy;
         o_src  = sel ? o2.src_rdy : o_f36.src_rdy;
         o_dat  = sel ? o2.data : o_f36.data;
         if (i_f36.src_rdy && !in_dst) all_rdy = 0;
         if (o_src && o_f36.dst_rdy) rx.push_back(o_dat);
         if (i_f36.src_rdy && in_dst) idx++;
         idle = (idx >= tx.size() && !o_src) ? idle + 1 : 0;
         cyc++;
      end
      if (cyc >= 3000) check("run timeout", 36'(cyc), 36'd0);
   endtask

   initial begin
      i_f36.data = '0; i_f36.src_rdy = 0; o_f36.dst_rdy = 0;
      i2.data = '0; i2.src_rdy = 0; o2.dst_rdy = 0;

      repeat (2) @(negedge clk);
      #1;
      check("reset dst_rdy", 36'(i_f36.dst_rdy), 36'd0);
      check("reset src_rdy", 36'(o_f36.src_rdy), 36'd0);
      check("reset data", o_f36.data, 36'd0);
`ifdef ETH_RX_FILTER_STATS_EN
      check("reset ok", 36'(ok), 36'd0);
`endif
      @(negedge clk);
      reset_n = 1;
      repeat (2) @(negedge clk);

      mk_frame(UCAST, 16'h0800, 16); run(0, 0, 0, 0); check_rx("ucast pass", 16);
      mk_frame(UCAST, 16'h0806, 16); run(0, 0, 0, 0); check_rx("type drop", 0);
      check("drop dst_rdy held", 36'(all_rdy), 36'd1);
      mk_frame(BCAST_ADDR, 16'h0800, 8); run(0, 0, 0, 0); check_rx("bcast pass", 8);
      mk_frame(UCAST, 16'h0800, 3); run(0, 0, 0, 0); check_rx("runt", 0);
      mk_frame(UCAST, 16'h0800, 8); run(0, 0, 0, 0); check_rx("after runt", 8);
      mk_frame(UCAST, 16'h0800, 12); run(0, 1, 0, 0); check_rx("backpressure", 12);
      mk_frame(UCAST, 16'h0800, 4); run(0, 0, 0, 0); check_rx("four word", 4);
      check("four word eof", 36'(rx.size() == 4 ? rx[3][EOF] : 1'b0), 36'd1);
      check("four word idle src", 36'(o_f36.src_rdy), 36'd0);
      check("four word idle dst", 36'(i_f36.dst_rdy), 36'd1);
`ifdef ETH_RX_FILTER_STATS_EN
      check("ok count", 36'(ok), 36'd5);
      check("drop count", 36'(drop), 36'd1);
      check("runt count", 36'(runt), 36'd1);
`endif

      mk_frame(UCAST, 16'h0800, 20); run(0, 0, 1, 6); check_rx("reset mid pass", 6);
`ifdef ETH_RX_FILTER_STATS_EN
      check("ok after reset", 36'(ok), 36'd0);
`endif
      mk_frame(UCAST, 16'h0800, 8); run(0, 0, 0, 0); check_rx("after reset", 8);
      mk_frame(48'h0050_c285_3ffe, 16'h0800, 6); run(0, 0, 0, 0); check_rx("dst drop", 0);

      // Two orphan header words, then a new sof restarts capture.
      mk_frame(UCAST, 16'h0800, 8);
      tx.push_front({4'b0000, UCAST[15:0], 16'hbeef});
      tx.push_front({4'b0001, UCAST[47:16]});
      run(0, 0, 0, 0); check_rx("sof restart", 8);

      mk_frame(UCAST, 16'h0800, 10); run(0, 0, 2, 6); check_rx("clear mid pass", 6);
      mk_frame(UCAST, 16'h0800, 8); run(0, 0, 0, 0); check_rx("after clear", 8);
`ifdef ETH_RX_FILTER_STATS_EN
      check("ok final", 36'(ok), 36'd4);
      check("drop final", 36'(drop), 36'd1);
      check("runt final", 36'(runt), 36'd0);
`endif

      @(negedge clk); clear = 1; i_f36.src_rdy = 0; i2.src_rdy = 0;
      @(negedge clk); clear = 0;
      mk_frame(BCAST_ADDR, 16'h0800, 8); run(1, 0, 0, 0); check_rx("nb bcast drop", 0);
      mk_frame(UCAST, 16'h0800, 8); run(1, 0, 0, 0); check_rx("nb ucast pass", 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
